// File: rtl/sec_display_drv_pkg.sv
// stopwatch_pkg: shared types and constants for the seconds display back-end.
//   conv_state_t : states of the binary-to-BCD conversion FSM
//   SEG_*        : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   AN_*         : active-low digit enables, an[0]=units, an[1]=tens
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_LOAD
  } conv_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  localparam logic [1:0] AN_UNITS  = 2'b10;
  localparam logic [1:0] AN_TENS   = 2'b01;
  localparam logic [1:0] AN_OFF    = 2'b11;

endpackage

// File: rtl/sec_display_drv_seg7_dec.sv
// seg7_dec: combinational 4-bit digit to active-low 7-segment decoder.
//   i_digit : digit value 0..15
//   o_seg   : segments {g,f,e,d,c,b,a}, active-low; 10..15 decode to blank
module seg7_dec
  import stopwatch_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sec_display_drv.sv
// sec_display_drv: stopwatch display back-end. Converts binary seconds to
// tens/units by repeated subtraction, multiplexes two common-anode digits
// and blinks the display while ring is asserted.
//   clk   : system clock, posedge
//   reset : synchronous, active-high
//   sec   : binary seconds 0..63 (60..63 show as 6/0..6/3)
//   ring  : alarm flag, level-sensitive; blinks the segments
//   seg   : segments {g,f,e,d,c,b,a}, active-low, registered
//   an    : digit enables, active-low, an[0]=units an[1]=tens, registered
//   busy  : high while a conversion is in progress
// Build option: define LEAD_ZERO_BLANK_EN to blank the tens digit when zero.
module sec_display_drv
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 50000,
  parameter int unsigned BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] sec,
  input  logic       ring,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       busy
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Conversion FSM state and datapath
  conv_state_t r_state, w_state_nxt;
  logic [5:0]  r_rem,   w_rem_nxt;
  logic [5:0]  r_cap,   w_cap_nxt;
  logic [2:0]  r_tcnt,  w_tcnt_nxt;
  logic [5:0]  r_sec_q, w_sec_q_nxt;
  logic [2:0]  r_tens,  w_tens_nxt;
  logic [3:0]  r_units, w_units_nxt;
  logic        r_busy,  w_busy_nxt;

  // Scan / blink
  logic [PRE_W-1:0] r_pre;
  logic [BLK_W-1:0] r_bcnt;
  logic             r_phase;   // 0 = visible, 1 = blank
  logic             r_ptr;     // 0 = units slot next, 1 = tens slot next
  logic [6:0]       r_seg;
  logic [1:0]       r_an;

  logic       w_tick;
  logic [3:0] w_digit;
  logic [6:0] w_code;
  logic       w_blank;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_cap   <= '0;
      r_tcnt  <= '0;
      r_sec_q <= '0;
      r_tens  <= '0;
      r_units <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_cap   <= w_cap_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_sec_q <= w_sec_q_nxt;
      r_tens  <= w_tens_nxt;
      r_units <= w_units_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_cap_nxt   = r_cap;
    w_tcnt_nxt  = r_tcnt;
    w_sec_q_nxt = r_sec_q;
    w_tens_nxt  = r_tens;
    w_units_nxt = r_units;
    w_busy_nxt  = r_busy;
    case (r_state)
      ST_IDLE: begin
        if (sec != r_sec_q) begin
          w_rem_nxt   = sec;
          w_cap_nxt   = sec;
          w_tcnt_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        if (r_rem >= 6'd10) begin
          w_rem_nxt  = r_rem - 6'd10;
          w_tcnt_nxt = r_tcnt + 3'd1;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_tens_nxt  = r_tcnt;
        w_units_nxt = r_rem[3:0];
        w_sec_q_nxt = r_cap;
        w_busy_nxt  = 1'b0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_tick  = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_digit = r_ptr ? {1'b0, r_tens} : r_units;

  seg7_dec u_dec (
    .i_digit (w_digit),
    .o_seg   (w_code)
  );

  // Phase only matters while ring is high, so a dropped ring is visible
  // in the same cycle even though the phase register clears one edge later.
`ifdef LEAD_ZERO_BLANK_EN
  assign w_blank = (ring && r_phase) || (r_ptr && (r_tens == 3'd0));
`else
  assign w_blank = ring && r_phase;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
      r_ptr <= 1'b0;
      r_seg <= SEG_BLANK;
      r_an  <= AN_OFF;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) begin
        r_ptr <= ~r_ptr;
        r_an  <= r_ptr ? AN_TENS : AN_UNITS;
        r_seg <= w_blank ? SEG_BLANK : w_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !ring) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_tick) begin
      if (r_bcnt == BLK_W'(BLINK_DIV - 1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt  <= r_bcnt + 1'b1;
      end
    end
  end

  assign seg  = r_seg;
  assign an   = r_an;
  assign busy = r_busy;

endmodule

// File: tb/tb_sec_display_drv.sv
module tb_sec_display_drv;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] sec = '0;
  logic       ring = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  sec_display_drv #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .sec   (sec),
    .ring  (ring),
    .seg   (seg),
    .an    (an),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference model: digits are sec/10 and sec%10, appearing sec/10+2 cycles
  // after capture; slots alternate every SCAN_DIV cycles starting with units;
  // while ring is high, tick k is blank when (k-1)/BLINK_DIV is odd.
  logic [6:0] codes [10];
  int         m_cyc, m_left, m_k, m_t, m_u, m_d;
  logic [5:0] m_sq, m_cap;
  logic [6:0] m_seg;
  logic [1:0] m_an;
  logic       m_busy, m_uslot, m_blank;

  initial begin
    codes[0] = 7'h40; codes[1] = 7'h79; codes[2] = 7'h24; codes[3] = 7'h30;
    codes[4] = 7'h19; codes[5] = 7'h12; codes[6] = 7'h02; codes[7] = 7'h78;
    codes[8] = 7'h00; codes[9] = 7'h10;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_cyc = 0; m_left = 0; m_k = 0; m_t = 0; m_u = 0;
      m_sq = '0; m_cap = '0; m_seg = 7'h7F; m_an = 2'b11; m_busy = 1'b0;
    end else begin
      m_cyc++;
      if (!ring) m_k = 0;
      if (m_cyc % SCAN_DIV == 0) begin
        m_uslot = ((m_cyc / SCAN_DIV) % 2) == 1;
        m_d     = m_uslot ? m_u : m_t;
        m_blank = 1'b0;
        if (ring) begin
          m_k++;
          m_blank = (((m_k - 1) / BLINK_DIV) % 2) == 1;
        end
`ifdef LEAD_ZERO_BLANK_EN
        if (!m_uslot && m_t == 0) m_blank = 1'b1;
`endif
        m_an  = m_uslot ? 2'b10 : 2'b01;
        m_seg = m_blank ? 7'h7F : codes[m_d];
      end
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_t = int'(m_cap) / 10;
          m_u = int'(m_cap) % 10;
          m_sq = m_cap;
          m_busy = 1'b0;
        end
      end else if (sec != m_sq) begin
        m_cap  = sec;
        m_left = int'(sec) / 10 + 2;
        m_busy = 1'b1;
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (seg !== 7'h7F || an !== 2'b11 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: seg=%h an=%b busy=%b required seg=7f an=11 busy=0", seg, an, busy);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg !== m_seg || an !== m_an || busy !== m_busy) begin
        n_err++;
        $display("FAIL reset_scan c%0d: seg=%h an=%b busy=%b required seg=%h an=%b busy=%b",
                 i, seg, an, busy, m_seg, m_an, m_busy);
      end
    end
    n_cmp++;
    if (an !== 2'b10 || seg !== 7'h40) begin
      n_err++;
      $display("FAIL first_tick: seg=%h an=%b required seg=40 an=10", seg, an);
    end
  endtask

  task automatic test_conv(input logic [5:0] v, input int exp_busy,
                           input logic [6:0] exp_u, input logic [6:0] exp_t);
    int nb;
    nb = 0;
    sec = v;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      n_cmp++;
      if (seg !== m_seg || an !== m_an || busy !== m_busy) begin
        n_err++;
        $display("FAIL conv_%0d c%0d: seg=%h an=%b busy=%b required seg=%h an=%b busy=%b",
                 v, i, seg, an, busy, m_seg, m_an, m_busy);
      end
    end
    n_cmp++;
    if (nb != exp_busy) begin
      n_err++;
      $display("FAIL busy_len_%0d: busy cycles=%0d required %0d", v, nb, exp_busy);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ((an === 2'b10 && seg !== exp_u) || (an === 2'b01 && seg !== exp_t) ||
          (an !== 2'b10 && an !== 2'b01)) begin
        n_err++;
        $display("FAIL digits_%0d: an=%b seg=%h required units=%h tens=%h", v, an, seg, exp_u, exp_t);
      end
    end
  endtask

  task automatic test_change_mid();
    int rises, nb;
    logic prev;
    rises = 0; nb = 0; prev = busy;
    sec = 6'd12;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nb++;
      if (busy === 1'b1 && prev === 1'b0) rises++;
      prev = busy;
      n_cmp++;
      if (seg !== m_seg || an !== m_an || busy !== m_busy) begin
        n_err++;
        $display("FAIL change_mid c%0d: seg=%h an=%b busy=%b required seg=%h an=%b busy=%b",
                 i, seg, an, busy, m_seg, m_an, m_busy);
      end
      if (i == 1) sec = 6'd45;
    end
    n_cmp++;
    if (rises != 2 || nb != 9) begin
      n_err++;
      $display("FAIL change_mid_busy: rises=%0d cycles=%0d required rises=2 cycles=9", rises, nb);
    end
  endtask

  task automatic test_blink();
    int nblank, nvis;
    nblank = 0; nvis = 0;
    sec = 6'd59;
    repeat (16) @(negedge clk);
    ring = 1'b1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (seg === 7'h7F) nblank++; else nvis++;
      n_cmp++;
      if (seg !== m_seg || an !== m_an) begin
        n_err++;
        $display("FAIL blink c%0d: seg=%h an=%b required seg=%h an=%b", i, seg, an, m_seg, m_an);
      end
    end
    n_cmp++;
    if (nblank == 0 || nvis == 0) begin
      n_err++;
      $display("FAIL blink_mix: blank=%0d visible=%0d required both nonzero", nblank, nvis);
    end
    ring = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg !== m_seg || an !== m_an) begin
        n_err++;
        $display("FAIL unblink c%0d: seg=%h an=%b required seg=%h an=%b", i, seg, an, m_seg, m_an);
      end
      if (i >= SCAN_DIV) begin
        n_cmp++;
        if (seg === 7'h7F) begin
          n_err++;
          $display("FAIL unblink_vis c%0d: seg=%h required a digit code", i, seg);
        end
      end
    end
  endtask

  task automatic test_lead_zero();
    logic [6:0] exp_t;
`ifdef LEAD_ZERO_BLANK_EN
    exp_t = 7'h7F;
`else
    exp_t = 7'h40;
`endif
    sec = 6'd5;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ((an === 2'b10 && seg !== 7'h12) || (an === 2'b01 && seg !== exp_t)) begin
        n_err++;
        $display("FAIL lead_zero: an=%b seg=%h required units=12 tens=%h", an, seg, exp_t);
      end
    end
  endtask

  task automatic test_reset_mid();
    sec = 6'd63;
    repeat (3) @(negedge clk);
    ring = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (seg !== 7'h7F || an !== 2'b11 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: seg=%h an=%b busy=%b required seg=7f an=11 busy=0", seg, an, busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      n_cmp++;
      if (seg !== m_seg || an !== m_an || busy !== m_busy) begin
        n_err++;
        $display("FAIL after_reset c%0d: seg=%h an=%b busy=%b required seg=%h an=%b busy=%b",
                 i, seg, an, busy, m_seg, m_an, m_busy);
      end
    end
    ring = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    for (int it = 0; it < 60; it++) begin
      sec  = 6'($urandom_range(0, 63));
      ring = ($urandom_range(0, 3) == 0);
      hold = $urandom_range(1, 15);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        n_cmp++;
        if (seg !== m_seg || an !== m_an || busy !== m_busy) begin
          n_err++;
          $display("FAIL random it%0d c%0d: seg=%h an=%b busy=%b required seg=%h an=%b busy=%b",
                   it, i, seg, an, busy, m_seg, m_an, m_busy);
        end
      end
    end
    ring = 1'b0;
  endtask

  initial begin
    test_reset();
    test_conv(6'd37, 5, 7'h78, 7'h30);
    test_conv(6'd63, 8, 7'h30, 7'h02);
    test_change_mid();
    test_blink();
    test_lead_zero();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sec_display_drv.md
Name: sec_display_drv

Overview:
Display back-end for the stopwatch. It consumes the 6-bit seconds value and the ring flag from the stopwatch counter. It converts seconds to tens/units with a sequential BCD conversion and time-multiplexes two common-anode 7-segment digits. It blinks the display while ring is asserted. It sits between the stopwatch core and the board pins.

Parameters:
SCAN_DIV, 50000, clk cycles per digit-scan tick (min 2)
BLINK_DIV, 250, scan ticks per blink half-period (min 1)

Ports:
clk    input   1  system clock; all logic on posedge
reset  input   1  synchronous, active-high reset
sec    input   6  binary seconds from stopwatch core, 0..63
ring   input   1  alarm flag from stopwatch core; level-sensitive
seg    output  7  segments {g,f,e,d,c,b,a}, active-low, registered
an     output  2  digit enables, active-low; an[0]=units, an[1]=tens, registered
busy   output  1  high while a conversion is in progress

Behaviour:
- Reset (sync, active-high):
  - seg=7'h7F (blank), an=2'b11 (both off), busy=0.
  - sec_q=0, tens_r=0, units_r=0.
  - FSM=IDLE, scan prescaler=0, blink counter=0, blink phase=visible, digit pointer=units.
- Conversion FSM (IDLE, CONV, LOAD):
  - IDLE: if sec != sec_q, capture rem<=sec, cap<=sec, tcnt<=0, go to CONV, busy<=1. Otherwise stay.
  - CONV: if rem>=10, then rem<=rem-10 and tcnt<=tcnt+1, stay. Otherwise go to LOAD.
  - LOAD: tens_r<=tcnt, units_r<=rem[3:0], sec_q<=cap, busy<=0, go to IDLE.
  - Latency from capture to updated digit registers is tcnt+2 cycles. Worst case is 8 cycles for sec=63.
- sec changing during CONV/LOAD is ignored. After returning to IDLE, the mismatch with sec_q triggers a new conversion.
- Inputs 60..63 are not clamped: tens=6, units=0..3.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and issues a one-cycle tick at SCAN_DIV-1, then wraps.
  - On each tick the digit pointer toggles, and an and seg are updated in the same cycle.
  - The first tick after reset drives the units digit (an=2'b10); the next tick drives tens (an=2'b01).
- seg holds the 7-segment code for the selected digit register as sampled at the tick. A digit update between ticks becomes visible at the next tick.
- Encoding (active-low, gfedcba):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - Codes 10..15 produce 7'h7F.
- Blink:
  - While ring=1, the blink counter counts scan ticks. At BLINK_DIV ticks it wraps and the phase toggles.
  - While phase=blank, the seg update writes 7'h7F. an still scans.
  - When ring=0, the counter clears and the phase forces visible on the same cycle.
  - ring rising starts with a visible phase.
- Reset mid-conversion or mid-blink aborts and returns to the reset state above.

Optional Feature:
LEAD_ZERO_BLANK_EN
- Defined: when tens_r==0, the tens-digit slot drives seg=7'h7F. an still scans, so seconds 0..9 show as a single digit.
- Undefined: the tens digit always shows, including a leading 0.

Decomposition:
- Package stopwatch_pkg holds:
  - FSM state typedef (IDLE/CONV/LOAD)
  - SEG_BLANK=7'h7F
  - the ten digit-code constants
  - AN_UNITS=2'b10, AN_TENS=2'b01, AN_OFF=2'b11
- One sub-module, seg7_dec: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected digit.
- FSM, prescaler and blink logic stay in the top module.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
- Reset 2 cycles then release -> seg=7'h7F, an=2'b11, busy=0. At the 4th clk after release, an=2'b10 and seg=7'h40.
- sec=6'd37 held -> busy=1 for exactly 5 cycles, then tens_r=3 and units_r=7. Scans then alternate an=2'b10/seg=7'h78 and an=2'b01/seg=7'h30.
- sec=6'd63 -> 8-cycle conversion latency; display shows 6/3 (7'h02, 7'h30).
- sec 12 -> 45 changed on the 2nd CONV cycle -> first result is 1/2, then busy re-asserts and the final result is 4/5.
- ring=1 with sec=59 -> seg alternates between digit codes and 7'h7F every 2 scan ticks. Dropping ring restores digit codes on the next tick.
- With LEAD_ZERO_BLANK_EN and sec=5 -> tens slot seg=7'h7F, units slot seg=7'h12. Without the macro, the tens slot shows 7'h40.
